// File: rtl/vga_pkg.sv
// Shared definitions for the VGA front-end: debounce FSM encoding and 25 MHz timing defaults.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  // 20 ms debounce, 0.5 s to first repeat, 0.1 s between repeats at 25 MHz
  localparam int DEBOUNCE_CYCLES_25M = 500000;
  localparam int REPEAT_DELAY_25M    = 12500000;
  localparam int REPEAT_PERIOD_25M   = 2500000;

endpackage

// File: rtl/vga_btn_cond_if.sv
// Button bundle between the board pins and vga_con: raw levels in, clean pulses/levels out.
interface vga_btn_cond_if;

  logic pb_enter_raw;
  logic pb_up_raw;
  logic pb_enter;
  logic pb_up;
  logic enter_held;
  logic up_held;

  // master is the board/stimulus side; slave is the conditioner
  modport master (
    output pb_enter_raw, pb_up_raw,
    input  pb_enter, pb_up, enter_held, up_held
  );

  modport slave (
    input  pb_enter_raw, pb_up_raw,
    output pb_enter, pb_up, enter_held, up_held
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop sync + 4-state debounce FSM; press pulse DEBOUNCE_CYCLES+3 edges after a stable
// press, held level likewise; no backpressure. Auto-repeat needs REPEAT=1 and VGA_BTN_REPEAT_EN.
module btn_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25M,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = REPEAT_DELAY_25M,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_25M,
  parameter bit REPEAT          = 1'b0
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("btn_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic             s1;
  logic             s2;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             rpt_hit;

`ifdef VGA_BTN_REPEAT_EN
  if (REPEAT) begin : g_repeat
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_phase;
    logic [RPT_W-1:0] rpt_target;

    // first repeat waits REPEAT_DELAY HELD cycles, later ones REPEAT_PERIOD
    assign rpt_target = rpt_phase ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
    assign rpt_hit    = (state == HELD) && s2 && ((rpt_cnt + 1'b1) == rpt_target);

    always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (state == HELD && s2) begin
        if (rpt_hit) begin
          rpt_cnt   <= '0;
          rpt_phase <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end else begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end
    end
  end else begin : g_no_repeat
    assign rpt_hit = 1'b0;
  end
`else
  assign rpt_hit = 1'b0;
`endif

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            pulse <= 1'b1;
            held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= REL_CHK;
            cnt   <= '0;
          end else begin
            pulse <= rpt_hit;
          end
        end
        REL_CHK: begin
          // a bounce back high returns to HELD silently
          if (s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_btn_cond.sv
// Enter/up pushbutton conditioner for vga_con: one pulse per press, DEBOUNCE_CYCLES+3 edges latency,
// no backpressure. Define VGA_BTN_REPEAT_EN to add auto-repeat pulses on pb_up while held.
module vga_btn_cond
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25M,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = REPEAT_DELAY_25M,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_25M
) (
  input logic           vga_clk,
  input logic           rst,
  vga_btn_cond_if.slave btn
);

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT          (1'b0)
  ) u_enter (
    .vga_clk (vga_clk),
    .rst     (rst),
    .raw     (btn.pb_enter_raw),
    .pulse   (btn.pb_enter),
    .held    (btn.enter_held)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT          (1'b1)
  ) u_up (
    .vga_clk (vga_clk),
    .rst     (rst),
    .raw     (btn.pb_up_raw),
    .pulse   (btn.pb_up),
    .held    (btn.up_held)
  );

endmodule

// File: tb/tb_vga_btn_cond.sv
// Directed bench for vga_btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_vga_btn_cond;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_btn_cond_if bif();

  vga_btn_cond #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .vga_clk (clk),
    .rst     (rst),
    .btn     (bif)
  );

  int n_chk = 0;
  int n_err = 0;

  // index i of each queue holds the output seen just after edge i+1 since the last clear
  bit pe_q[$];
  bit pu_q[$];
  bit eh_q[$];
  bit uh_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit e, input bit u);
    bif.pb_enter_raw = e;
    bif.pb_up_raw    = u;
    @(posedge clk);
    #1;
    pe_q.push_back(bif.pb_enter);
    pu_q.push_back(bif.pb_up);
    eh_q.push_back(bif.enter_held);
    uh_q.push_back(bif.up_held);
  endtask

  task automatic steps(input int n, input bit e, input bit u);
    for (int i = 0; i < n; i++) step(e, u);
  endtask

  task automatic clear_q();
    pe_q.delete();
    pu_q.delete();
    eh_q.delete();
    uh_q.delete();
  endtask

  function automatic int ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  function automatic int first_hi(input bit q[$]);
    foreach (q[i]) if (q[i]) return i + 1;
    return 0;
  endfunction

  int exp_up[$];
  int act_up[$];

  initial begin
    bif.pb_enter_raw = 1'b0;
    bif.pb_up_raw    = 1'b0;

    // reset state
    #12;
    check("rst_pb_enter",   bif.pb_enter,   0);
    check("rst_pb_up",      bif.pb_up,      0);
    check("rst_enter_held", bif.enter_held, 0);
    check("rst_up_held",    bif.up_held,    0);
    @(posedge clk);
    #2 rst = 1'b0;
    steps(3, 1'b0, 1'b0);

    // up bounces 1,0,1,0 then stays high
    clear_q();
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
    check("bounce_no_early_pulse", ones(pu_q), 0);
    clear_q();
    steps(10, 1'b0, 1'b1);
    check("bounce_up_count",   ones(pu_q), 1);
    check("bounce_up_edge",    first_hi(pu_q), 7);
    check("bounce_held_pre",   uh_q[5], 0);
    check("bounce_held_rise",  uh_q[6], 1);
    clear_q();
    steps(12, 1'b0, 1'b0);
    check("up_release_no_pulse", ones(pu_q), 0);
    check("up_release_held",     uh_q[11], 0);

    // enter glitch of 3 cycles is rejected
    clear_q();
    steps(3, 1'b1, 1'b0);
    steps(10, 1'b0, 1'b0);
    check("glitch_pulse", ones(pe_q), 0);
    check("glitch_held",  ones(eh_q), 0);

    // enter press, then release with bounce
    clear_q();
    steps(10, 1'b1, 1'b0);
    check("enter_count", ones(pe_q), 1);
    check("enter_edge",  first_hi(pe_q), 7);
    clear_q();
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    check("rel_bounce_pulse", ones(pe_q), 0);
    check("rel_bounce_held",  ones(eh_q), 4);
    clear_q();
    steps(12, 1'b0, 1'b0);
    check("rel_pulse",     ones(pe_q), 0);
    check("rel_held_pre",  eh_q[5], 1);
    check("rel_held_fall", eh_q[6], 0);

    // reset while enter HELD and up in PRESS_CHK
    steps(10, 1'b1, 1'b0);
    steps(4, 1'b1, 1'b1);
    check("pre_rst_enter_held", bif.enter_held, 1);
    #2 rst = 1'b1;
    #1;
    check("async_enter_held", bif.enter_held, 0);
    check("async_up_held",    bif.up_held,    0);
    check("async_pb_up",      bif.pb_up,      0);
    clear_q();
    steps(2, 1'b1, 1'b1);
    check("in_rst_pulses", ones(pe_q) + ones(pu_q), 0);
    #2 rst = 1'b0;
    clear_q();
    steps(10, 1'b1, 1'b1);
    check("post_rst_up_count",    ones(pu_q), 1);
    check("post_rst_up_edge",     first_hi(pu_q), 7);
    check("post_rst_enter_count", ones(pe_q), 1);
    check("post_rst_enter_edge",  first_hi(pe_q), 7);

    // simultaneous press from idle
    steps(12, 1'b0, 1'b0);
    clear_q();
    steps(10, 1'b1, 1'b1);
    check("simul_enter_count", ones(pe_q), 1);
    check("simul_up_count",    ones(pu_q), 1);
    check("simul_enter_edge",  first_hi(pe_q), 7);
    check("simul_up_edge",     first_hi(pu_q), 7);
    steps(12, 1'b0, 1'b0);

    // long hold: repeats on up only when the feature is built in
`ifdef VGA_BTN_REPEAT_EN
    exp_up = '{7, 15, 18, 21, 24, 27, 30};
`else
    exp_up = '{7};
`endif
    clear_q();
    steps(30, 1'b1, 1'b1);
    steps(10, 1'b0, 1'b0);
    act_up.delete();
    foreach (pu_q[i]) if (pu_q[i]) act_up.push_back(i + 1);
    check("hold_up_count",    act_up.size(), exp_up.size());
    foreach (exp_up[k])
      check($sformatf("hold_up_edge%0d", k), (k < act_up.size()) ? act_up[k] : -1, exp_up[k]);
    check("hold_enter_count", ones(pe_q), 1);
    check("hold_enter_edge",  first_hi(pe_q), 7);
    check("hold_up_held_end", uh_q[39], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_btn_cond.md
Name: vga_btn_cond

Overview:
- Pushbutton conditioner placed directly upstream of vga_con.
- Takes the raw, asynchronous, bouncing board buttons for "enter" and "up".
- Synchronises and debounces each button, then delivers clean single-cycle press pulses on pb_enter / pb_up.
- Also provides stable held levels.
- Runs entirely in the vga_clk domain, so vga_con's pattern-select logic sees exactly one event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or release (20 ms at 25 MHz); legal range >=1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).
- REPEAT_DELAY, 12500000, held cycles before the first auto-repeat pulse on pb_up (used only with the optional feature).
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- vga_clk  in  1  pixel clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pb_enter_raw  in  1  raw enter button, asynchronous, active-high.
- pb_up_raw  in  1  raw up button, asynchronous, active-high.
- pb_enter  out  1  one-cycle pulse per accepted enter press.
- pb_up  out  1  one-cycle pulse per accepted up press (plus repeats if enabled).
- enter_held  out  1  debounced enter level.
- up_held  out  1  debounced up level.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, counters, FSMs and outputs go to 0; both FSMs enter IDLE.
- Each button has an independent path: 2-flop synchroniser (s1 -> s2), then a 4-state FSM clocked on vga_clk with counter cnt[CNT_W-1:0].
- FSM states and transitions:
  - IDLE: s2=1 -> PRESS_CHK, cnt<=0.
  - PRESS_CHK: s2=0 -> IDLE (glitch rejected, no pulse). cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse<=1. Otherwise cnt++.
  - HELD: s2=0 -> REL_CHK, cnt<=0.
  - REL_CHK: s2=1 -> HELD (bounce on release ignored, no new pulse). cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Pulse output:
  - Registered and high for exactly one cycle: the first cycle in HELD after PRESS_CHK.
  - Never asserted on release.
- Latency: count the first edge that samples raw=1 as edge 1, with raw stable thereafter. The pulse is high in the cycle after edge DEBOUNCE_CYCLES+3 (edge 7 for DEBOUNCE_CYCLES=4).
- Held output: held = (state==HELD || state==REL_CHK), registered. It falls DEBOUNCE_CYCLES+3 edges after raw stably returns to 0.
- Simultaneous presses: the two paths are fully independent, so both pulses may assert in the same cycle; there is no priority.
- Reset mid-operation: the operation is abandoned and there is no pulse during reset. If raw is still high after reset deasserts, the button is treated as a new press and pulses after the normal latency measured from release.
- Counter never wraps: the compare at DEBOUNCE_CYCLES-1 always precedes overflow, and cnt holds in IDLE/HELD.

Optional Feature:
- Macro: VGA_BTN_REPEAT_EN.
- Defined: pb_up path only.
  - A repeat counter runs while in HELD. Index 0 is the initial pulse cycle.
  - Extra one-cycle pulses at HELD indices REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, and so on.
  - The counter clears on leaving HELD. A REL_CHK->HELD return restarts it at 0 with no immediate pulse.
  - Enter never repeats.
- Undefined: no repeat logic or counter is synthesised; exactly one pulse per press.

Decomposition:
- Shared package vga_pkg holds:
  - FSM state localparams: IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3.
  - Default debounce/repeat constants for 25 MHz.
- Natural sub-module: btn_debounce (synchroniser + FSM + counter; ports vga_clk, rst, raw, pulse, held; optional repeat logic gated by a REPEAT parameter plus the macro).
- vga_btn_cond instantiates btn_debounce twice: enter with REPEAT=0, up with REPEAT=1.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- pb_up_raw bounces 1,0,1,0 one cycle each, then stays 1 -> exactly one pb_up pulse, in the cycle after the 7th edge from the stable-high start; up_held rises with it.
- pb_enter_raw high for 3 cycles, then 0 -> no pb_enter pulse; enter_held stays 0.
- Held enter released with 1,0,1 bounce, then stable 0 -> no pulse on release; enter_held falls 7 edges after stable 0.
- rst asserted during PRESS_CHK with raw held high -> all outputs 0 asynchronously; after rst release, one pulse 7 edges later.
- Both raws rise on the same edge and stay high -> pb_enter and pb_up pulse in the same cycle, once each.
- With VGA_BTN_REPEAT_EN, pb_up_raw held for 30 cycles -> pb_up pulses at HELD indices 0, 8, 11, 14, 17, 20, 23 (bounded by release); pb_enter held identically -> single pulse.
